// File: rtl/entrada_tempo_mmss_pkg.sv
// Shared definitions for the MM:SS timer entry block: digit width, digit limits and FSM codes.
package entrada_tempo_mmss_pkg;

  localparam int DIGIT_W          = 4;
  localparam int SEC_TENS_MAX_DEF = 5;
  localparam int UNIT_MAX_DEF     = 9;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_ENTRY = 3'b001,
    ST_LOAD  = 3'b010,
    ST_RUN   = 3'b011,
    ST_PAUSE = 3'b100
  } state_t;

  // True when a BCD digit does not exceed the given limit.
  function automatic logic digit_le(digit_t d, digit_t lim);
    return d <= lim;
  endfunction

endpackage

// File: rtl/entrada_tempo_mmss_if.sv
// Keypad/command inputs and parallel-load outputs between the entry block and its environment.
interface entrada_tempo_mmss_if;
  import entrada_tempo_mmss_pkg::*;

  logic       key_valid;
  digit_t     key_digit;
  logic       key_clear;
  logic       start;
  logic       stop;
  logic       timer_zero;

  logic       load;
  logic       en;
  digit_t     min_t;
  digit_t     min_u;
  digit_t     sec_t;
  digit_t     sec_u;
  logic       entry_err;
  logic       done;
  logic [2:0] state;

  // The entry block writes the load interface and consumes keypad/commands.
  modport master (
    input  key_valid, key_digit, key_clear, start, stop, timer_zero,
    output load, en, min_t, min_u, sec_t, sec_u, entry_err, done, state
  );

  // The environment (keypad, counter chain) sees the opposite directions.
  modport slave (
    output key_valid, key_digit, key_clear, start, stop, timer_zero,
    input  load, en, min_t, min_u, sec_t, sec_u, entry_err, done, state
  );

endinterface

// File: rtl/entrada_tempo_mmss_registro_digitos.sv
// Four-digit BCD shift register holding the MM:SS entry, with clear and a valid-time flag.
module registro_digitos_mmss
  import entrada_tempo_mmss_pkg::*;
#(
  parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF,
  parameter int UNIT_MAX     = UNIT_MAX_DEF
) (
  input  logic   clk,
  input  logic   clear,
  input  logic   shift_en,
  input  digit_t shift_in,
  input  logic   clr_digits,
  output digit_t min_t,
  output digit_t min_u,
  output digit_t sec_t,
  output digit_t sec_u,
  output logic   valid_time
);

  digit_t min_t_q, min_u_q, sec_t_q, sec_u_q;
  digit_t min_t_d, min_u_d, sec_t_d, sec_u_d;
  logic   nonzero;
  logic   digits_legal;

  // Next digit values: clearing wins over shifting; a shift pushes the oldest digit out.
  always_comb begin
    min_t_d = min_t_q;
    min_u_d = min_u_q;
    sec_t_d = sec_t_q;
    sec_u_d = sec_u_q;
    if (clr_digits) begin
      min_t_d = '0;
      min_u_d = '0;
      sec_t_d = '0;
      sec_u_d = '0;
    end else if (shift_en) begin
      min_t_d = min_u_q;
      min_u_d = sec_t_q;
      sec_t_d = sec_u_q;
      sec_u_d = shift_in;
    end
  end

  // Digit storage, zeroed by the asynchronous clear.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      min_t_q <= '0;
      min_u_q <= '0;
      sec_t_q <= '0;
      sec_u_q <= '0;
    end else begin
      min_t_q <= min_t_d;
      min_u_q <= min_u_d;
      sec_t_q <= sec_t_d;
      sec_u_q <= sec_u_d;
    end
  end

  // A time is loadable when it is not 00:00 and every digit fits its counter stage.
  always_comb begin
    nonzero      = (min_t_q != '0) || (min_u_q != '0) || (sec_t_q != '0) || (sec_u_q != '0);
    digits_legal = digit_le(min_t_q, digit_t'(UNIT_MAX)) &&
                   digit_le(min_u_q, digit_t'(UNIT_MAX)) &&
                   digit_le(sec_t_q, digit_t'(SEC_TENS_MAX)) &&
                   digit_le(sec_u_q, digit_t'(UNIT_MAX));
    valid_time   = nonzero && digits_legal;
  end

  assign min_t = min_t_q;
  assign min_u = min_u_q;
  assign sec_t = sec_t_q;
  assign sec_u = sec_u_q;

endmodule

// File: rtl/entrada_tempo_mmss.sv
// MM:SS timer entry controller: collects keypad digits, loads the counter chain and drives count enable.
module entrada_tempo_mmss
  import entrada_tempo_mmss_pkg::*;
#(
  parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF,
  parameter int UNIT_MAX     = UNIT_MAX_DEF
) (
  input logic                  clk,
  input logic                  clear,
  entrada_tempo_mmss_if.master bus
);

  state_t state_q, state_d;
  logic   load_q, load_d;
  logic   en_q, en_d;
  logic   entry_err_q, entry_err_d;
  logic   done_q, done_d;
  logic   shift_en;
  logic   clr_digits;
  logic   valid_time;
  logic   key_ok;

  assign key_ok = digit_le(bus.key_digit, digit_t'(UNIT_MAX));

  registro_digitos_mmss #(
    .SEC_TENS_MAX (SEC_TENS_MAX),
    .UNIT_MAX     (UNIT_MAX)
  ) u_registro (
    .clk        (clk),
    .clear      (clear),
    .shift_en   (shift_en),
    .shift_in   (bus.key_digit),
    .clr_digits (clr_digits),
    .min_t      (bus.min_t),
    .min_u      (bus.min_u),
    .sec_t      (bus.sec_t),
    .sec_u      (bus.sec_u),
    .valid_time (valid_time)
  );

  // Next state and registered outputs; strobe priority is key_clear > stop > start > key_valid.
  always_comb begin
    state_d     = state_q;
    load_d      = 1'b0;
    en_d        = 1'b0;
    entry_err_d = 1'b0;
    done_d      = 1'b0;
    shift_en    = 1'b0;
    clr_digits  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (bus.key_clear) begin
          clr_digits = 1'b1;
          state_d    = ST_IDLE;
        end else if (bus.stop) begin
          state_d = state_q;
        end else if (bus.start) begin
          if (state_q == ST_ENTRY) begin
            if (valid_time) begin
              state_d = ST_LOAD;
              load_d  = 1'b1;
            end else begin
              entry_err_d = 1'b1;
            end
          end
        end else if (bus.key_valid) begin
          if (key_ok) begin
            shift_en = 1'b1;
            state_d  = ST_ENTRY;
          end else begin
            entry_err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
        en_d    = 1'b1;
      end
      ST_RUN: begin
        if (bus.key_clear) begin
          clr_digits = 1'b1;
          state_d    = ST_IDLE;
        end else if (bus.timer_zero) begin
          clr_digits = 1'b1;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end else if (bus.stop) begin
          state_d = ST_PAUSE;
        end else begin
          en_d = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (bus.key_clear || bus.stop) begin
          clr_digits = 1'b1;
          state_d    = ST_IDLE;
        end else if (bus.start) begin
          state_d = ST_RUN;
          en_d    = 1'b1;
        end
      end
      default: begin
        clr_digits = 1'b1;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State and output registers; clear drops en immediately so a running count freezes without done.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q     <= ST_IDLE;
      load_q      <= 1'b0;
      en_q        <= 1'b0;
      entry_err_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      en_q        <= en_d;
      entry_err_q <= entry_err_d;
      done_q      <= done_d;
    end
  end

  assign bus.load      = load_q;
  assign bus.en        = en_q;
  assign bus.entry_err = entry_err_q;
  assign bus.done      = done_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_entrada_tempo_mmss.sv
// Self-checking bench for entrada_tempo_mmss: directed scenarios plus random strobes against a behavioural model.
module tb_entrada_tempo_mmss;

  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_LOAD  = 2;
  localparam int M_RUN   = 3;
  localparam int M_PAUSE = 4;

  logic clk = 1'b0;
  logic clear;

  entrada_tempo_mmss_if bus ();

  entrada_tempo_mmss dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  // 10 time-unit clock.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // The entry is kept as a plain decimal number MMSS; the mode uses the published state codes.
  int m_mode;
  int m_entry;
  int m_err;
  int m_done;
  bit model_active = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_entry = 0;
    m_err   = 0;
    m_done  = 0;
  endtask

  function automatic bit entry_loadable(input int e);
    return (e != 0) && (((e / 10) % 10) <= 5);
  endfunction

  // One clock edge of the intended behaviour, evaluated from the inputs present at that edge.
  task automatic model_step();
    int kd;
    kd     = int'(bus.key_digit);
    m_err  = 0;
    m_done = 0;
    case (m_mode)
      M_IDLE, M_ENTRY: begin
        if (bus.key_clear) begin
          m_entry = 0;
          m_mode  = M_IDLE;
        end else if (bus.stop) begin
          m_err = 0;
        end else if (bus.start) begin
          if (m_mode == M_ENTRY) begin
            if (entry_loadable(m_entry)) m_mode = M_LOAD;
            else m_err = 1;
          end
        end else if (bus.key_valid) begin
          if (kd <= 9) begin
            m_entry = (m_entry * 10 + kd) % 10000;
            m_mode  = M_ENTRY;
          end else begin
            m_err = 1;
          end
        end
      end
      M_LOAD: m_mode = M_RUN;
      M_RUN: begin
        if (bus.key_clear) begin
          m_entry = 0;
          m_mode  = M_IDLE;
        end else if (bus.timer_zero) begin
          m_entry = 0;
          m_mode  = M_IDLE;
          m_done  = 1;
        end else if (bus.stop) begin
          m_mode = M_PAUSE;
        end
      end
      M_PAUSE: begin
        if (bus.key_clear || bus.stop) begin
          m_entry = 0;
          m_mode  = M_IDLE;
        end else if (bus.start) begin
          m_mode = M_RUN;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic compare_all();
    checkOutput("state", int'(bus.state), m_mode);
    checkOutput("load", int'(bus.load), int'(m_mode == M_LOAD));
    checkOutput("en", int'(bus.en), int'(m_mode == M_RUN));
    checkOutput("entry_err", int'(bus.entry_err), m_err);
    checkOutput("done", int'(bus.done), m_done);
    checkOutput("min_t", int'(bus.min_t), m_entry / 1000);
    checkOutput("min_u", int'(bus.min_u), (m_entry / 100) % 10);
    checkOutput("sec_t", int'(bus.sec_t), (m_entry / 10) % 10);
    checkOutput("sec_u", int'(bus.sec_u), m_entry % 10);
  endtask

  // Compare process: advance the model on every active edge and check the DUT shortly after.
  initial begin
    forever begin
      @(posedge clk);
      if (model_active) begin
        model_step();
        #1;
        compare_all();
      end
    end
  end

  // Drive one cycle of inputs from the falling edge, return just after the following rising edge.
  task automatic applyStimulus(input bit kv, input logic [3:0] kd, input bit kc,
                               input bit st, input bit sp, input bit tz);
    @(negedge clk);
    bus.key_valid  = kv;
    bus.key_digit  = kd;
    bus.key_clear  = kc;
    bus.start      = st;
    bus.stop       = sp;
    bus.timer_zero = tz;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic key(input logic [3:0] d);
    applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_start();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic press_stop();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic press_clear_key();
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    clear          = 1'b1;
    bus.key_valid  = 1'b0;
    bus.key_digit  = 4'd0;
    bus.key_clear  = 1'b0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.timer_zero = 1'b0;
    model_reset();

    // Reset state.
    #12;
    checkOutput("reset_state", int'(bus.state), 0);
    checkOutput("reset_load", int'(bus.load), 0);
    checkOutput("reset_en", int'(bus.en), 0);
    checkOutput("reset_err", int'(bus.entry_err), 0);
    checkOutput("reset_done", int'(bus.done), 0);
    checkOutput("reset_digits", int'({bus.min_t, bus.min_u, bus.sec_t, bus.sec_u}), 0);
    @(negedge clk);
    clear        = 1'b0;
    model_active = 1'b1;

    // Entry 12:30, start, single load then count enable.
    key(4'd1); key(4'd2); key(4'd3); key(4'd0);
    checkOutput("t1_entry_state", int'(bus.state), 1);
    press_start();
    checkOutput("t1_load_state", int'(bus.state), 2);
    checkOutput("t1_load", int'(bus.load), 1);
    checkOutput("t1_load_en", int'(bus.en), 0);
    checkOutput("t1_digits", int'({bus.min_t, bus.min_u, bus.sec_t, bus.sec_u}), 16'h1230);
    idle(1);
    checkOutput("t1_run_state", int'(bus.state), 3);
    checkOutput("t1_run_load", int'(bus.load), 0);
    checkOutput("t1_run_en", int'(bus.en), 1);

    // Pause and resume without reload; stop beats start when both arrive together.
    press_stop();
    checkOutput("t5_pause_state", int'(bus.state), 4);
    checkOutput("t5_pause_en", int'(bus.en), 0);
    press_start();
    checkOutput("t5_resume_state", int'(bus.state), 3);
    checkOutput("t5_resume_en", int'(bus.en), 1);
    checkOutput("t5_resume_load", int'(bus.load), 0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t5_stop_wins", int'(bus.state), 4);
    press_start();
    checkOutput("t5_rerun", int'(bus.state), 3);

    // Terminal count: done pulse, digits cleared, back to IDLE.
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t4_state", int'(bus.state), 0);
    checkOutput("t4_en", int'(bus.en), 0);
    checkOutput("t4_done", int'(bus.done), 1);
    checkOutput("t4_digits", int'({bus.min_t, bus.min_u, bus.sec_t, bus.sec_u}), 0);
    idle(1);
    checkOutput("t4_done_once", int'(bus.done), 0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("tz_idle_ignored", int'(bus.done), 0);

    // 12:70 has an illegal seconds-tens digit.
    key(4'd1); key(4'd2); key(4'd7); key(4'd0);
    press_start();
    checkOutput("t2_err", int'(bus.entry_err), 1);
    checkOutput("t2_state", int'(bus.state), 1);
    checkOutput("t2_no_load", int'(bus.load), 0);
    idle(1);
    checkOutput("t2_err_once", int'(bus.entry_err), 0);
    press_clear_key();
    checkOutput("t2_cleared", int'(bus.state), 0);

    // 00:00 rejected; a non-BCD key is rejected and leaves the digits alone.
    key(4'd0); key(4'd0); key(4'd0); key(4'd0);
    press_start();
    checkOutput("t3_zero_err", int'(bus.entry_err), 1);
    key(4'd5);
    key(4'hA);
    checkOutput("t3_bad_key_err", int'(bus.entry_err), 1);
    checkOutput("t3_digits_kept", int'({bus.min_t, bus.min_u, bus.sec_t, bus.sec_u}), 16'h0005);
    press_clear_key();

    // Fifth digit pushes the oldest out.
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    checkOutput("fifth_digit", int'({bus.min_t, bus.min_u, bus.sec_t, bus.sec_u}), 16'h2345);
    press_clear_key();

    // Asynchronous clear between edges while running.
    key(4'd0); key(4'd1); key(4'd0); key(4'd0);
    press_start();
    idle(1);
    checkOutput("t6_running", int'(bus.en), 1);
    #1;
    model_active = 1'b0;
    clear        = 1'b1;
    #1;
    checkOutput("t6_async_en", int'(bus.en), 0);
    checkOutput("t6_async_state", int'(bus.state), 0);
    checkOutput("t6_async_digits", int'({bus.min_t, bus.min_u, bus.sec_t, bus.sec_u}), 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t6_no_done", int'(bus.done), 0);
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    model_active = 1'b1;

    // Random strobes; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 99) < 45,
                    4'($urandom_range(0, 11)),
                    $urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 7,
                    $urandom_range(0, 99) < 6);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
